// File: rtl/commit_tracker.sv
// Retirement monitor: registers retire lanes into difftest commit slots, keeps cycle/instr counters, latches the sim trap.
// Latency: all outputs one cycle after the retire; no backpressure, the retire stream is never stalled.
module commit_tracker #(
    parameter int         COMMIT_W    = 2,
    parameter int         XLEN        = 64,
    parameter logic [6:0] TRAP_OPCODE = 7'h6b,
    parameter int         CODE_W      = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [COMMIT_W-1:0]      rt_valid,
    input  logic [COMMIT_W*XLEN-1:0] rt_pc,
    input  logic [COMMIT_W*32-1:0]   rt_inst,
    input  logic [COMMIT_W-1:0]      rt_wen,
    input  logic [COMMIT_W*5-1:0]    rt_wdest,
    input  logic [COMMIT_W*XLEN-1:0] rt_wdata,
    input  logic [XLEN-1:0]          a0_data,
    input  logic                     perf_clean,
    input  logic                     perf_dump,
    output logic [COMMIT_W-1:0]      cmt_valid,
    output logic [COMMIT_W*XLEN-1:0] cmt_pc,
    output logic [COMMIT_W*32-1:0]   cmt_inst,
    output logic [COMMIT_W-1:0]      cmt_wen,
    output logic [COMMIT_W*8-1:0]    cmt_wdest,
    output logic [COMMIT_W*XLEN-1:0] cmt_wdata,
    output logic                     trap,
    output logic [CODE_W-1:0]        trap_code,
    output logic [XLEN-1:0]          trap_pc,
    output logic [63:0]              cycle_cnt,
    output logic [63:0]              instr_cnt,
    output logic                     dump_valid,
    output logic [63:0]              dump_cycle,
    output logic [63:0]              dump_instr
);

    localparam int CNT_W = $clog2(COMMIT_W + 1);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t                     state_q;
    logic [COMMIT_W-1:0]        cmt_valid_q;
    logic [COMMIT_W*XLEN-1:0]   cmt_pc_q;
    logic [COMMIT_W*32-1:0]     cmt_inst_q;
    logic [COMMIT_W-1:0]        cmt_wen_q;
    logic [COMMIT_W*8-1:0]      cmt_wdest_q;
    logic [COMMIT_W*XLEN-1:0]   cmt_wdata_q;
    logic                       trap_q;
    logic [CODE_W-1:0]          trap_code_q;
    logic [XLEN-1:0]            trap_pc_q;
    logic [63:0]                cycle_q;
    logic [63:0]                instr_q;
    logic                       dump_valid_q;
    logic [63:0]                dump_cycle_q;
    logic [63:0]                dump_instr_q;

    logic [COMMIT_W-1:0]        mask_d;
    logic                       trap_hit_d;
    logic [XLEN-1:0]            trap_pc_d;
    logic [CNT_W-1:0]           ncommit_d;
    logic [COMMIT_W-1:0]        wen_d;
    logic [63:0]                cycle_d;
    logic [63:0]                instr_d;
    logic                       unused_a0;

    assign unused_a0 = ^a0_data[XLEN-1:CODE_W];

    // Walk lanes oldest-first; once a trap commits, younger lanes are squashed.
    always_comb begin
        mask_d     = '0;
        trap_hit_d = 1'b0;
        trap_pc_d  = '0;
        ncommit_d  = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (rt_valid[i] && !trap_hit_d) begin
                mask_d[i] = 1'b1;
                ncommit_d = ncommit_d + 1'b1;
                if (rt_inst[i*32 +: 7] == TRAP_OPCODE) begin
                    trap_hit_d = 1'b1;
                    trap_pc_d  = rt_pc[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        wen_d = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            wen_d[i] = rt_wen[i] && (rt_wdest[i*5 +: 5] != 5'd0);
        end
    end

    assign cycle_d = perf_clean ? 64'd0 : cycle_q + 64'd1;
    assign instr_d = perf_clean ? 64'd0 : instr_q + {{(64-CNT_W){1'b0}}, ncommit_d};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            cmt_valid_q  <= '0;
            cmt_pc_q     <= '0;
            cmt_inst_q   <= '0;
            cmt_wen_q    <= '0;
            cmt_wdest_q  <= '0;
            cmt_wdata_q  <= '0;
            trap_q       <= 1'b0;
            trap_code_q  <= '0;
            trap_pc_q    <= '0;
            cycle_q      <= '0;
            instr_q      <= '0;
            dump_valid_q <= 1'b0;
            dump_cycle_q <= '0;
            dump_instr_q <= '0;
        end else begin
            // Snapshot sees the pre-update counters, so it also works alongside a clean.
            dump_valid_q <= perf_dump;
            if (perf_dump) begin
                dump_cycle_q <= cycle_q;
                dump_instr_q <= instr_q;
            end
            case (state_q)
                RUN: begin
                    cmt_valid_q <= mask_d;
                    for (int i = 0; i < COMMIT_W; i++) begin
                        if (mask_d[i]) begin
                            cmt_pc_q[i*XLEN +: XLEN]    <= rt_pc[i*XLEN +: XLEN];
                            cmt_inst_q[i*32 +: 32]      <= rt_inst[i*32 +: 32];
                            cmt_wen_q[i]                <= wen_d[i];
                            cmt_wdest_q[i*8 +: 8]       <= {3'b000, rt_wdest[i*5 +: 5]};
                            cmt_wdata_q[i*XLEN +: XLEN] <= rt_wdata[i*XLEN +: XLEN];
                        end
                    end
                    cycle_q <= cycle_d;
                    instr_q <= instr_d;
                    if (trap_hit_d) begin
                        trap_q      <= 1'b1;
                        trap_code_q <= a0_data[CODE_W-1:0];
                        trap_pc_q   <= trap_pc_d;
                        state_q     <= HALTED;
                    end
                end
                HALTED: begin
                    cmt_valid_q <= '0;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign cmt_valid  = cmt_valid_q;
    assign cmt_pc     = cmt_pc_q;
    assign cmt_inst   = cmt_inst_q;
    assign cmt_wen    = cmt_wen_q;
    assign cmt_wdest  = cmt_wdest_q;
    assign cmt_wdata  = cmt_wdata_q;
    assign trap       = trap_q;
    assign trap_code  = trap_code_q;
    assign trap_pc    = trap_pc_q;
    assign cycle_cnt  = cycle_q;
    assign instr_cnt  = instr_q;
    assign dump_valid = dump_valid_q;
    assign dump_cycle = dump_cycle_q;
    assign dump_instr = dump_instr_q;

endmodule

// File: tb/tb_commit_tracker.sv
// Scoreboard bench for commit_tracker: driver pushes model expectations, monitor pops and compares after each edge.
module tb_commit_tracker;
    localparam int W  = 2;
    localparam int X  = 64;
    localparam int CW = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [W-1:0]     rt_valid = '0;
    logic [W*X-1:0]   rt_pc = '0;
    logic [W*32-1:0]  rt_inst = '0;
    logic [W-1:0]     rt_wen = '0;
    logic [W*5-1:0]   rt_wdest = '0;
    logic [W*X-1:0]   rt_wdata = '0;
    logic [X-1:0]     a0_data = '0;
    logic             perf_clean = 1'b0;
    logic             perf_dump = 1'b0;
    logic [W-1:0]     cmt_valid;
    logic [W*X-1:0]   cmt_pc;
    logic [W*32-1:0]  cmt_inst;
    logic [W-1:0]     cmt_wen;
    logic [W*8-1:0]   cmt_wdest;
    logic [W*X-1:0]   cmt_wdata;
    logic             trap;
    logic [CW-1:0]    trap_code;
    logic [X-1:0]     trap_pc;
    logic [63:0]      cycle_cnt, instr_cnt;
    logic             dump_valid;
    logic [63:0]      dump_cycle, dump_instr;

    commit_tracker #(.COMMIT_W(W), .XLEN(X), .TRAP_OPCODE(7'h6b), .CODE_W(CW)) dut (
        .clock(clock), .reset(reset), .rt_valid(rt_valid), .rt_pc(rt_pc), .rt_inst(rt_inst),
        .rt_wen(rt_wen), .rt_wdest(rt_wdest), .rt_wdata(rt_wdata), .a0_data(a0_data),
        .perf_clean(perf_clean), .perf_dump(perf_dump), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
        .cmt_inst(cmt_inst), .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata),
        .trap(trap), .trap_code(trap_code), .trap_pc(trap_pc), .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt), .dump_valid(dump_valid), .dump_cycle(dump_cycle), .dump_instr(dump_instr)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0]    v;
        logic [W*X-1:0]  pc;
        logic [W*32-1:0] inst;
        logic [W-1:0]    wen;
        logic [W*8-1:0]  wdest;
        logic [W*X-1:0]  wdata;
        logic            trap;
        logic [CW-1:0]   code;
        logic [X-1:0]    tpc;
        logic [63:0]     cyc;
        logic [63:0]     ins;
        logic            dv;
        logic [63:0]     dc;
        logic [63:0]     di;
    } exp_t;

    exp_t q[$];
    exp_t m;
    exp_t e;
    bit   m_halt;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m      = '0;
        m_halt = 1'b0;
        q.delete();
    endtask

    // Reference: retire stream is taken in program order and truncated after the first trap.
    task automatic drive(input logic [W-1:0] v, input logic [W*X-1:0] pc, input logic [W*32-1:0] inst,
                         input logic [W-1:0] wen, input logic [W*5-1:0] wd, input logic [W*X-1:0] wdat,
                         input logic [X-1:0] a0, input logic clean, input logic dump);
        int n;
        bit stopped;
        rt_valid = v; rt_pc = pc; rt_inst = inst; rt_wen = wen; rt_wdest = wd; rt_wdata = wdat;
        a0_data = a0; perf_clean = clean; perf_dump = dump;
        n = 0;
        stopped = 1'b0;
        m.dv = dump;
        if (dump) begin
            m.dc = m.cyc;
            m.di = m.ins;
        end
        if (!m_halt) begin
            m.v = '0;
            for (int l = 0; l < W; l++) begin
                if (v[l] && !stopped) begin
                    m.v[l]              = 1'b1;
                    n++;
                    m.pc[l*X +: X]      = pc[l*X +: X];
                    m.inst[l*32 +: 32]  = inst[l*32 +: 32];
                    m.wen[l]            = wen[l] && (wd[l*5 +: 5] != 0);
                    m.wdest[l*8 +: 8]   = 8'(wd[l*5 +: 5]);
                    m.wdata[l*X +: X]   = wdat[l*X +: X];
                    if (inst[l*32 +: 7] == 7'h6b) begin
                        stopped = 1'b1;
                        m.trap  = 1'b1;
                        m.code  = a0[CW-1:0];
                        m.tpc   = pc[l*X +: X];
                    end
                end
            end
            if (clean) begin
                m.cyc = 0;
                m.ins = 0;
            end else begin
                m.cyc = m.cyc + 64'd1;
                m.ins = m.ins + 64'(n);
            end
            if (stopped) m_halt = 1'b1;
        end else begin
            m.v = '0;
        end
        q.push_back(m);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rinst(input bit is_trap);
        logic [31:0] r;
        r = $urandom;
        if (is_trap) r[6:0] = 7'h6b;
        else if (r[6:0] == 7'h6b) r[0] = ~r[0];
        return r;
    endfunction

    task automatic rnd_cycle(input int trap_pct);
        logic [W*32-1:0] inst;
        logic [W*X-1:0]  pc, wdat;
        logic [W*5-1:0]  wd;
        for (int l = 0; l < W; l++) begin
            inst[l*32 +: 32] = rinst($urandom_range(99) < trap_pct);
            pc[l*X +: X]     = {$urandom, $urandom};
            wdat[l*X +: X]   = {$urandom, $urandom};
            wd[l*5 +: 5]     = 5'($urandom_range(31));
        end
        drive(W'($urandom), pc, inst, W'($urandom), wd, wdat, {$urandom, $urandom},
              $urandom_range(24) == 0, $urandom_range(5) == 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cmt_valid"}, cmt_valid, 0);
        chk({tag, "_cmt_pc"}, cmt_pc, 0);
        chk({tag, "_cmt_inst"}, cmt_inst, 0);
        chk({tag, "_cmt_wen"}, cmt_wen, 0);
        chk({tag, "_cmt_wdest"}, cmt_wdest, 0);
        chk({tag, "_cmt_wdata"}, cmt_wdata, 0);
        chk({tag, "_trap"}, trap, 0);
        chk({tag, "_trap_code"}, trap_code, 0);
        chk({tag, "_trap_pc"}, trap_pc, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
        chk({tag, "_instr_cnt"}, instr_cnt, 0);
        chk({tag, "_dump_valid"}, dump_valid, 0);
        chk({tag, "_dump_cycle"}, dump_cycle, 0);
        chk({tag, "_dump_instr"}, dump_instr, 0);
    endtask

    // Assert reset between edges, check outputs clear at once, release on a later negedge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        rt_valid = '0; perf_clean = 1'b0; perf_dump = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (reset && q.size() > 0) begin
                e = q.pop_front();
                chk("cmt_valid", cmt_valid, e.v);
                chk("cmt_pc", cmt_pc, e.pc);
                chk("cmt_inst", cmt_inst, e.inst);
                chk("cmt_wen", cmt_wen, e.wen);
                chk("cmt_wdest", cmt_wdest, e.wdest);
                chk("cmt_wdata", cmt_wdata, e.wdata);
                chk("trap", trap, e.trap);
                chk("trap_code", trap_code, e.code);
                chk("trap_pc", trap_pc, e.tpc);
                chk("cycle_cnt", cycle_cnt, e.cyc);
                chk("instr_cnt", instr_cnt, e.ins);
                chk("dump_valid", dump_valid, e.dv);
                chk("dump_cycle", dump_cycle, e.dc);
                chk("dump_instr", dump_instr, e.di);
            end
        end
    end

    initial begin
        model_reset();
        #3;
        check_zero("por");
        @(negedge clock);
        reset = 1'b1;

        idle(10);
        chk("idle_cycle_cnt", cycle_cnt, 10);
        chk("idle_instr_cnt", instr_cnt, 0);

        for (int k = 0; k < 3; k++)
            drive(2'b11, {64'h8000_0004, 64'h8000_0000}, {32'h0000_0013, 32'h0000_0293},
                  2'b11, {5'd0, 5'd5}, {64'hdead, 64'h1234}, '0, 1'b0, 1'b0);
        chk("pair_cmt_wen1", cmt_wen[1], 0);
        chk("pair_cmt_wdest0", cmt_wdest[7:0], 8'd5);
        chk("pair_instr_cnt", instr_cnt, 6);

        drive(2'b11, {64'h8000_0014, 64'h8000_0010}, {32'h0000_0013, 32'h0000_006b},
              2'b00, '0, '0, 64'h2a, 1'b0, 1'b0);
        chk("trap0_cmt_valid", cmt_valid, 2'b01);
        chk("trap0_trap", trap, 1);
        chk("trap0_code", trap_code, 8'h2a);
        chk("trap0_pc", trap_pc, 64'h8000_0010);
        chk("trap0_instr_cnt", instr_cnt, 7);
        for (int k = 0; k < 5; k++) rnd_cycle(0);
        chk("halted_cycle_cnt", cycle_cnt, 14);
        chk("halted_instr_cnt", instr_cnt, 7);

        do_reset("midtrap_rst");
        drive(2'b10, {64'h9000_0004, 64'h9000_0000}, {32'h0000_006b, 32'h0000_0013},
              2'b00, '0, '0, 64'h55, 1'b0, 1'b0);
        chk("trap1_cmt_valid", cmt_valid, 2'b10);
        chk("trap1_trap", trap, 1);
        chk("trap1_pc", trap_pc, 64'h9000_0004);
        chk("trap1_instr_cnt", instr_cnt, 1);
        idle(2);

        do_reset("rst2");
        for (int k = 0; k < 20; k++)
            drive(2'b11, {64'h100, 64'hfc}, {32'h13, 32'h13}, 2'b01, {5'd3, 5'd4}, {64'd1, 64'd2}, '0, 1'b0, 1'b0);
        idle(80);
        chk("pre_dump_cycle_cnt", cycle_cnt, 100);
        chk("pre_dump_instr_cnt", instr_cnt, 40);
        drive('0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1);
        chk("dump_valid_pulse", dump_valid, 1);
        chk("dump_cycle_snap", dump_cycle, 100);
        chk("dump_instr_snap", dump_instr, 40);
        chk("clean_cycle_cnt", cycle_cnt, 0);
        chk("clean_instr_cnt", instr_cnt, 0);
        drive('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        drive('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        idle(1);

        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 200; k++) rnd_cycle(s == 0 ? 0 : 2);
            do_reset("seg_rst");
        end

        idle(2);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
